// File: rtl/eco32_core_idu_sbd_pkg.sv
// Shared types for the IDU register-file scoreboard: sweep FSM states and the
// {valid, tag} entry layout.
package eco32_core_idu_sbd_pkg;

   typedef enum logic [1:0] {
      SWEEP_ALL,
      SWEEP_THR,
      IDLE
   } sbd_state_e;

   // Widest tag any instance may use; the stored word is narrowed to TAG_W+1.
   localparam int SBD_TAG_W_MAX = 8;

   typedef struct packed {
      logic                     valid;
      logic [SBD_TAG_W_MAX-1:0] tag;
   } sbd_entry_t;

   // Packs an entry so that valid sits directly above a tag_w-bit tag.
   function automatic logic [SBD_TAG_W_MAX:0] sbd_entry(input int tag_w,
                                                        input logic valid,
                                                        input logic [SBD_TAG_W_MAX-1:0] tag);
      sbd_entry_t e;
      e.valid = valid;
      e.tag   = tag;
      return ({{SBD_TAG_W_MAX{1'b0}}, e.valid} << tag_w) | {1'b0, e.tag};
   endfunction

endpackage

// File: rtl/eco32_core_idu_sbd_mem.sv
// Distributed-RAM store for scoreboard entries: one synchronous word write port,
// a lower-priority valid-bit clear port, and NRP asynchronous read ports.
module eco32_core_idu_sbd_mem #(
   parameter int AW  = 6,
   parameter int DW  = 4,
   parameter int NRP = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DW-1:0]     wdata,
   input  logic              cwe,
   input  logic [AW-1:0]     caddr,
   input  logic [NRP*AW-1:0] raddr,
   output logic [NRP*DW-1:0] rdata
);

   logic [DW-1:0] mem [1<<AW];

   // NOTE: the array has no reset; the owner clears it with a sweep so it can
   // map onto LUT RAM, which has no reset pin.
   always_ff @(posedge clk) begin
      if (cwe && !(we && (waddr == caddr)))
         mem[caddr][DW-1] <= 1'b0;
      if (we)
         mem[waddr] <= wdata;
   end

   for (genvar i = 0; i < NRP; i++) begin : g_rd
      assign rdata[i*DW +: DW] = mem[raddr[i*AW +: AW]];
   end

endmodule

// File: rtl/eco32_core_idu_rfu_sbd.sv
// Register-file scoreboard: per-thread {valid, tag} per register, set at issue,
// cleared at writeback on tag match, wiped by a sweep FSM on reset and flush.
module eco32_core_idu_rfu_sbd
   import eco32_core_idu_sbd_pkg::*;
#(
   parameter int THREADS = 2,
   parameter int TW      = (THREADS > 1) ? $clog2(THREADS) : 1,
   parameter int ADDR_W  = 5,
   parameter int TAG_W   = 3,
   parameter int NRD     = 3,
   parameter int BYPASS  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  o_ready,
   input  logic                  i_flush_req,
   input  logic [TW-1:0]         i_flush_thid,
   input  logic [NRD*TW-1:0]     i_rd_thid,
   input  logic [NRD*ADDR_W-1:0] i_rd_addr,
   output logic [NRD-1:0]        o_rd_busy,
   output logic [NRD*TAG_W-1:0]  o_rd_tag,
   input  logic                  i_set_ena,
   input  logic [TW-1:0]         i_set_thid,
   input  logic [ADDR_W-1:0]     i_set_addr,
   input  logic [TAG_W-1:0]      i_set_tag,
   input  logic                  i_clr_ena,
   input  logic [TW-1:0]         i_clr_thid,
   input  logic [ADDR_W-1:0]     i_clr_addr,
   input  logic [TAG_W-1:0]      i_clr_tag,
   output logic                  o_clr_stale
);

   localparam int IW    = TW + ADDR_W;
   localparam int DEPTH = THREADS << ADDR_W;
   localparam int EW    = TAG_W + 1;

   sbd_state_e state, state_nxt;
   logic [IW-1:0]  cnt, cnt_nxt;
   logic [TW-1:0]  flush_thid, flush_thid_nxt;

   logic                  idle;
   logic [IW-1:0]         set_idx, clr_idx, sweep_idx, waddr;
   logic [EW-1:0]         set_word, wdata, clr_word;
   logic                  set_we, clr_match, clr_we, we;
   logic [(NRD+1)*IW-1:0] raddr;
   logic [(NRD+1)*EW-1:0] rdata;

   assign idle      = (state == IDLE);
   assign set_idx   = {i_set_thid, i_set_addr};
   assign clr_idx   = {i_clr_thid, i_clr_addr};
   assign sweep_idx = (state == SWEEP_THR) ? {flush_thid, cnt[ADDR_W-1:0]} : cnt;

   // The extra read port looks up the clear target before the edge.
   assign clr_word  = rdata[NRD*EW +: EW];
   assign clr_match = clr_word[TAG_W] && (clr_word[TAG_W-1:0] == i_clr_tag);

   // A set to the same entry overrides the clear, so the clear port stays quiet.
   assign set_we = !rst && idle && i_set_ena;
   assign clr_we = !rst && idle && i_clr_ena && clr_match &&
                   !(set_we && (set_idx == clr_idx));

   assign set_word = EW'(sbd_entry(TAG_W, 1'b1, SBD_TAG_W_MAX'(i_set_tag)));
   assign we       = set_we || (!rst && !idle);
   assign waddr    = idle ? set_idx : sweep_idx;
   assign wdata    = idle ? set_word : EW'(sbd_entry(TAG_W, 1'b0, '0));

   for (genvar i = 0; i < NRD; i++) begin : g_raddr
      assign raddr[i*IW +: IW] = {i_rd_thid[i*TW +: TW], i_rd_addr[i*ADDR_W +: ADDR_W]};
   end
   assign raddr[NRD*IW +: IW] = clr_idx;

   eco32_core_idu_sbd_mem #(
      .AW  (IW),
      .DW  (EW),
      .NRP (NRD + 1)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .cwe   (clr_we),
      .caddr (clr_idx),
      .raddr (raddr),
      .rdata (rdata)
   );

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [EW-1:0] view;
      always_comb begin
         view = rdata[i*EW +: EW];
         if (BYPASS != 0) begin
            if (set_we && (raddr[i*IW +: IW] == set_idx))
               view = set_word;
            else if (clr_we && (raddr[i*IW +: IW] == clr_idx))
               view[TAG_W] = 1'b0;
         end
      end
      // Mid-sweep contents are meaningless, so every operand reports busy.
      assign o_rd_busy[i]              = view[TAG_W] || !idle;
      assign o_rd_tag[i*TAG_W +: TAG_W] = view[TAG_W-1:0];
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case leaves one unassigned and infers a latch.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      flush_thid_nxt = flush_thid;
      case (state)
         SWEEP_ALL: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == IW'(DEPTH - 1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         SWEEP_THR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt[ADDR_W-1:0] == '1) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         IDLE: begin
            if (i_flush_req) begin
               state_nxt      = SWEEP_THR;
               cnt_nxt        = '0;
               flush_thid_nxt = i_flush_thid;
            end
         end
         default: begin
            state_nxt = SWEEP_ALL;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SWEEP_ALL;
         cnt         <= '0;
         flush_thid  <= '0;
         o_ready     <= 1'b0;
         o_clr_stale <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         flush_thid  <= flush_thid_nxt;
         o_ready     <= (state_nxt == IDLE);
         o_clr_stale <= idle && i_clr_ena && !clr_match;
      end
   end

endmodule

// File: tb/tb_eco32_core_idu_rfu_sbd.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based scoreboard model, on a BYPASS=0 and a BYPASS=1 instance.
module tb_eco32_core_idu_rfu_sbd;

   localparam int THREADS = 2;
   localparam int TW      = 1;
   localparam int ADDR_W  = 5;
   localparam int TAG_W   = 3;
   localparam int NRD     = 3;
   localparam int NE      = THREADS << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic                  flush_req  = 1'b0;
   logic [TW-1:0]         flush_thid = '0;
   logic [NRD*TW-1:0]     rd_thid    = '0;
   logic [NRD*ADDR_W-1:0] rd_addr    = '0;
   logic                  set_ena    = 1'b0;
   logic [TW-1:0]         set_thid   = '0;
   logic [ADDR_W-1:0]     set_addr   = '0;
   logic [TAG_W-1:0]      set_tag    = '0;
   logic                  clr_ena    = 1'b0;
   logic [TW-1:0]         clr_thid   = '0;
   logic [ADDR_W-1:0]     clr_addr   = '0;
   logic [TAG_W-1:0]      clr_tag    = '0;

   logic                 ready0, ready1, stale0, stale1;
   logic [NRD-1:0]       busy0, busy1;
   logic [NRD*TAG_W-1:0] tag0, tag1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   eco32_core_idu_rfu_sbd #(.THREADS(THREADS), .TW(TW), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
                            .NRD(NRD), .BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .o_ready(ready0),
      .i_flush_req(flush_req), .i_flush_thid(flush_thid),
      .i_rd_thid(rd_thid), .i_rd_addr(rd_addr), .o_rd_busy(busy0), .o_rd_tag(tag0),
      .i_set_ena(set_ena), .i_set_thid(set_thid), .i_set_addr(set_addr), .i_set_tag(set_tag),
      .i_clr_ena(clr_ena), .i_clr_thid(clr_thid), .i_clr_addr(clr_addr), .i_clr_tag(clr_tag),
      .o_clr_stale(stale0)
   );

   eco32_core_idu_rfu_sbd #(.THREADS(THREADS), .TW(TW), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
                            .NRD(NRD), .BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .o_ready(ready1),
      .i_flush_req(flush_req), .i_flush_thid(flush_thid),
      .i_rd_thid(rd_thid), .i_rd_addr(rd_addr), .o_rd_busy(busy1), .o_rd_tag(tag1),
      .i_set_ena(set_ena), .i_set_thid(set_thid), .i_set_addr(set_addr), .i_set_tag(set_tag),
      .i_clr_ena(clr_ena), .i_clr_thid(clr_thid), .i_clr_addr(clr_addr), .i_clr_tag(clr_tag),
      .o_clr_stale(stale1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit       mv [NE];
   bit [2:0] mt [NE];
   int       q [$];       // indexes still waiting to be wiped; empty = ready
   bit       stale_exp = 1'b0;
   bit       cmp_en    = 1'b0;

   function automatic int idx(input logic [TW-1:0] th, input logic [ADDR_W-1:0] a);
      return int'(th) * 32 + int'(a);
   endfunction

   always @(posedge clk) begin : model
      int si, ci;
      si = idx(set_thid, set_addr);
      ci = idx(clr_thid, clr_addr);
      if (rst) begin
         q.delete();
         for (int i = 0; i < NE; i++) q.push_back(i);
         stale_exp = 1'b0;
      end else if (q.size() != 0) begin
         mv[q.pop_front()] = 1'b0;
         stale_exp = 1'b0;
      end else begin
         stale_exp = clr_ena && !(mv[ci] && mt[ci] == clr_tag);
         if (clr_ena && !stale_exp) mv[ci] = 1'b0;
         if (set_ena) begin
            mv[si] = 1'b1;
            mt[si] = set_tag;
         end
         if (flush_req)
            for (int a = 0; a < 32; a++) q.push_back(idx(flush_thid, ADDR_W'(a)));
      end
   end

   function automatic void exp_read(input int p, input bit byp, output bit b, output bit [2:0] t);
      int i, si, ci;
      i  = idx(rd_thid[p*TW +: TW], rd_addr[p*ADDR_W +: ADDR_W]);
      si = idx(set_thid, set_addr);
      ci = idx(clr_thid, clr_addr);
      b  = mv[i];
      t  = mt[i];
      if (q.size() != 0) begin
         b = 1'b1;
      end else if (byp && !rst) begin
         if (clr_ena && mv[ci] && mt[ci] == clr_tag && ci == i) b = 1'b0;
         if (set_ena && si == i) begin
            b = 1'b1;
            t = set_tag;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         bit       eb;
         bit [2:0] et;
         check("ready0", ready0, q.size() == 0);
         check("ready1", ready1, q.size() == 0);
         check("stale0", stale0, stale_exp);
         check("stale1", stale1, stale_exp);
         for (int p = 0; p < NRD; p++) begin
            exp_read(p, 1'b0, eb, et);
            check($sformatf("busy0[%0d]", p), busy0[p], eb);
            if (eb && q.size() == 0) check($sformatf("tag0[%0d]", p), tag0[p*TAG_W +: TAG_W], et);
            exp_read(p, 1'b1, eb, et);
            check($sformatf("busy1[%0d]", p), busy1[p], eb);
            if (eb && q.size() == 0) check($sformatf("tag1[%0d]", p), tag1[p*TAG_W +: TAG_W], et);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int p, input int th, input int a);
      rd_thid[p*TW +: TW]         = TW'(th);
      rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
   endtask

   task automatic do_set(input int th, input int a, input int tg);
      set_ena = 1'b1; set_thid = TW'(th); set_addr = ADDR_W'(a); set_tag = TAG_W'(tg);
      step();
      set_ena = 1'b0;
   endtask

   task automatic check_all_clear(input string name);
      for (int i = 0; i < NE; i++) begin
         set_rd(0, i / 32, i % 32);
         #1;
         check(name, busy0[0], 1'b0);
      end
   endtask

   initial begin
      int low;
      repeat (3) step();
      cmp_en = 1'b1;
      rst    = 1'b0;

      // Reset sweep: ready only after the 64th edge.
      for (int k = 1; k <= 64; k++) begin
         step();
         check("reset_ready", ready0, k == 64);
      end
      check_all_clear("reset_clear");

      // Set, then read from own and other thread.
      do_set(0, 5, 3);
      set_rd(0, 0, 5);
      set_rd(1, 1, 5);
      #1;
      check("set_busy", busy0[0], 1'b1);
      check("set_tag", tag0[2:0], 3'd3);
      check("other_thread_idle", busy0[1], 1'b0);

      // Stale clear, then matching clear.
      clr_ena = 1'b1; clr_thid = 0; clr_addr = 5; clr_tag = 3'd2;
      step();
      clr_ena = 1'b0;
      #1;
      check("stale_pulse", stale0, 1'b1);
      check("stale_keeps_busy", busy0[0], 1'b1);
      clr_ena = 1'b1; clr_tag = 3'd3;
      step();
      clr_ena = 1'b0;
      #1;
      check("clear_busy", busy0[0], 1'b0);
      check("clear_no_stale", stale0, 1'b0);

      // Bypass makes a set visible in the issuing cycle.
      set_ena = 1'b1; set_thid = 0; set_addr = 9; set_tag = 3'd6;
      set_rd(1, 0, 9);
      #1;
      check("bypass_set_busy", busy1[1], 1'b1);
      check("bypass_set_tag", tag1[5:3], 3'd6);
      check("nobypass_set_busy", busy0[1], 1'b0);
      step();
      set_ena = 1'b0;

      // Same-cycle set and clear on one entry: set wins.
      do_set(1, 7, 1);
      set_ena = 1'b1; set_thid = 1; set_addr = 7; set_tag = 3'd1;
      clr_ena = 1'b1; clr_thid = 1; clr_addr = 7; clr_tag = 3'd1;
      set_rd(0, 1, 7);
      #1;
      check("bypass_setclr_busy", busy1[0], 1'b1);
      check("bypass_setclr_tag", tag1[2:0], 3'd1);
      step();
      set_ena = 1'b0;
      clr_ena = 1'b0;
      #1;
      check("setclr_busy", busy0[0], 1'b1);
      check("setclr_tag", tag0[2:0], 3'd1);
      check("setclr_no_stale", stale0, 1'b0);

      // Flush thread 1.
      do_set(0, 3, 2);
      do_set(1, 3, 4);
      flush_req = 1'b1; flush_thid = 1'b1;
      step();
      flush_req = 1'b0;
      set_rd(0, 0, 0);
      low = 0;
      while (ready0 !== 1'b1 && low < 100) begin
         low++;
         #1;
         check("sweep_forced_busy", busy0[0], 1'b1);
         step();
      end
      check("flush_low_cycles", low, 32);
      set_rd(0, 1, 3);
      set_rd(1, 1, 7);
      set_rd(2, 0, 3);
      #1;
      check("flushed_t1_r3", busy0[0], 1'b0);
      check("flushed_t1_r7", busy0[1], 1'b0);
      check("kept_t0_r3_busy", busy0[2], 1'b1);
      check("kept_t0_r3_tag", tag0[8:6], 3'd2);
      set_rd(2, 0, 9);
      #1;
      check("kept_t0_r9_busy", busy0[2], 1'b1);
      check("kept_t0_r9_tag", tag0[8:6], 3'd6);

      // Reset in the middle of a flush restarts the full sweep.
      do_set(1, 12, 5);
      flush_req = 1'b1; flush_thid = 1'b1;
      step();
      flush_req = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      low = 0;
      while (ready0 !== 1'b1 && low < 200) begin
         low++;
         step();
      end
      check("reset_sweep_cycles", low, 64);
      check_all_clear("post_reset_clear");

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         int ci;
         set_ena  = 1'($urandom_range(0, 1));
         set_thid = TW'($urandom_range(0, 1));
         set_addr = ADDR_W'($urandom_range(0, 7));
         set_tag  = TAG_W'($urandom);
         clr_ena  = 1'($urandom_range(0, 1));
         clr_thid = TW'($urandom_range(0, 1));
         clr_addr = ADDR_W'($urandom_range(0, 7));
         ci       = idx(clr_thid, clr_addr);
         clr_tag  = ($urandom_range(0, 3) != 0) ? mt[ci] : TAG_W'($urandom);
         flush_req  = ($urandom_range(0, 99) == 0);
         flush_thid = TW'($urandom_range(0, 1));
         for (int p = 0; p < NRD; p++)
            set_rd(p, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
         step();
      end
      set_ena = 1'b0;
      clr_ena = 1'b0;
      flush_req = 1'b0;
      repeat (2) step();
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
